// File: rtl/trans_layer_param.sv
// Parametrised transaction layer: a main FIFO fans out into NUM_VC virtual-channel
// FIFOs by VC field, an arbiter drains the VCs into NUM_DEST destination FIFOs by
// destination field, and an init/idle/active/error FSM supervises the flow.

// Generic FIFO with registered read port, count-based full/empty and threshold flags.
module tlp_fifo #(
  parameter int unsigned DW = 6,
  parameter int unsigned AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  input  logic [AW:0]   th_hi_i,
  input  logic [AW:0]   th_lo_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          afull_o,
  output logic          aempty_o,
  output logic          err_o
);
  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          do_push, do_pop;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign afull_o  = (count_q >= th_hi_i);
  assign aempty_o = (count_q <= th_lo_i);
  assign dout_o   = dout_q;
  assign valid_o  = valid_q;

  // Accept/reject decisions, pointer and count updates; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    err_o    = (push_i && !do_push) || (pop_i && empty_o);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    dout_d  = do_pop ? mem_q[rd_ptr_q] : dout_q;
    valid_d = do_pop;
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer, count and read-port registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end
endmodule

module trans_layer_param #(
  parameter int unsigned DW        = 6,
  parameter int unsigned VC_BITS   = 1,
  parameter int unsigned DEST_BITS = 1,
  parameter int unsigned AW_MAIN   = 2,
  parameter int unsigned AW_VC     = 4,
  parameter int unsigned AW_D      = 2,
  localparam int unsigned NUM_VC   = 2**VC_BITS,
  localparam int unsigned NUM_DEST = 2**DEST_BITS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init,
  input  logic                        arb_mode,
  input  logic [2*(AW_MAIN+1)-1:0]    th_main,
  input  logic [2*(AW_VC+1)-1:0]      th_vc,
  input  logic [2*(AW_D+1)-1:0]       th_d,
  input  logic [DW-1:0]               data_in,
  input  logic                        push_main,
  input  logic [NUM_DEST-1:0]         pop_d,
  output logic [NUM_DEST*DW-1:0]      data_out,
  output logic [NUM_DEST-1:0]         valid_out,
  output logic [NUM_DEST-1:0]         dest_empty,
  output logic [NUM_VC+NUM_DEST:0]    err_vec,
  output logic                        error_out,
  output logic                        active_out,
  output logic                        idle_out
);
  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_e;

  state_e state_q, state_d;

  logic [2*(AW_MAIN+1)-1:0] th_main_q, th_main_d;
  logic [2*(AW_VC+1)-1:0]   th_vc_q,   th_vc_d;
  logic [2*(AW_D+1)-1:0]    th_d_q,    th_d_d;
  logic [NUM_VC+NUM_DEST:0] err_vec_q, err_vec_d;
  logic [VC_BITS-1:0]       rr_ptr_q,  rr_ptr_d;

  logic                     xfer_en;
  logic                     all_empty;

  // Main FIFO
  logic                     pop_main;
  logic [DW-1:0]            m_dout;
  logic                     m_valid, m_empty, m_full, m_af, m_ae, m_err;
  logic [VC_BITS-1:0]       m_id;

  // VC FIFOs
  logic [DW-1:0]            vc_dout [NUM_VC];
  logic [NUM_VC-1:0]        vc_push, vc_pop, vc_valid, vc_empty, vc_full, vc_af, vc_ae, vc_err;
  logic [DW-1:0]            vc_word;
  logic                     vc_any;
  logic [DEST_BITS-1:0]     vc_dest;
  logic                     grant_vld;
  logic [VC_BITS-1:0]       grant_idx;
  logic [VC_BITS-1:0]       cand;

  // Destination FIFOs
  logic [DW-1:0]            d_dout [NUM_DEST];
  logic [NUM_DEST-1:0]      d_push, d_valid, d_empty, d_full, d_af, d_ae, d_err;

  assign xfer_en   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign all_empty = m_empty && (&vc_empty) && (&d_empty);

  assign pop_main = xfer_en && !m_empty && !(|vc_af);
  assign m_id     = m_dout[DW-1 -: VC_BITS];

  tlp_fifo #(.DW(DW), .AW(AW_MAIN)) u_main (
    .clk_i    (clk),
    .rst_ni   (reset),
    .push_i   (push_main),
    .pop_i    (pop_main),
    .din_i    (data_in),
    .th_hi_i  (th_main_q[2*(AW_MAIN+1)-1 -: AW_MAIN+1]),
    .th_lo_i  (th_main_q[AW_MAIN:0]),
    .dout_o   (m_dout),
    .valid_o  (m_valid),
    .empty_o  (m_empty),
    .full_o   (m_full),
    .afull_o  (m_af),
    .aempty_o (m_ae),
    .err_o    (m_err)
  );

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign vc_push[g] = m_valid && (m_id == VC_BITS'(g));

    tlp_fifo #(.DW(DW), .AW(AW_VC)) u_vc (
      .clk_i    (clk),
      .rst_ni   (reset),
      .push_i   (vc_push[g]),
      .pop_i    (vc_pop[g]),
      .din_i    (m_dout),
      .th_hi_i  (th_vc_q[2*(AW_VC+1)-1 -: AW_VC+1]),
      .th_lo_i  (th_vc_q[AW_VC:0]),
      .dout_o   (vc_dout[g]),
      .valid_o  (vc_valid[g]),
      .empty_o  (vc_empty[g]),
      .full_o   (vc_full[g]),
      .afull_o  (vc_af[g]),
      .aempty_o (vc_ae[g]),
      .err_o    (vc_err[g])
    );
  end

  // Select the single VC word read this cycle (at most one VC is granted per cycle).
  always_comb begin
    vc_word = '0;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      if (vc_valid[k]) vc_word = vc_dout[k];
    end
  end

  assign vc_any  = |vc_valid;
  assign vc_dest = vc_word[DW-1-VC_BITS -: DEST_BITS];

  // Arbiter; loops walk the candidates in reverse so the last hit is the winning one.
  always_comb begin
    vc_pop    = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (xfer_en && !(&vc_empty) && !(|d_af)) begin
      grant_vld = 1'b1;
      if (!arb_mode) begin
        for (int unsigned k = NUM_VC; k > 0; k--) begin
          if (!vc_empty[k-1]) grant_idx = VC_BITS'(k-1);
        end
      end else begin
        for (int unsigned k = NUM_VC; k > 0; k--) begin
          cand = rr_ptr_q + VC_BITS'(k);
          if (!vc_empty[cand]) grant_idx = cand;
        end
      end
      vc_pop[grant_idx] = 1'b1;
    end
    rr_ptr_d = (grant_vld && arb_mode) ? grant_idx : rr_ptr_q;
  end

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    assign d_push[g] = vc_any && (vc_dest == DEST_BITS'(g));

    tlp_fifo #(.DW(DW), .AW(AW_D)) u_d (
      .clk_i    (clk),
      .rst_ni   (reset),
      .push_i   (d_push[g]),
      .pop_i    (pop_d[g]),
      .din_i    (vc_word),
      .th_hi_i  (th_d_q[2*(AW_D+1)-1 -: AW_D+1]),
      .th_lo_i  (th_d_q[AW_D:0]),
      .dout_o   (d_dout[g]),
      .valid_o  (d_valid[g]),
      .empty_o  (d_empty[g]),
      .full_o   (d_full[g]),
      .afull_o  (d_af[g]),
      .aempty_o (d_ae[g]),
      .err_o    (d_err[g])
    );

    assign data_out[g*DW +: DW] = d_dout[g];
  end

  assign valid_out  = d_valid;
  assign dest_empty = d_empty;
  assign err_vec    = err_vec_q;

  // FSM next state, threshold capture and sticky error accumulation.
  always_comb begin
    state_d   = state_q;
    th_main_d = th_main_q;
    th_vc_d   = th_vc_q;
    th_d_d    = th_d_q;
    err_vec_d = err_vec_q | {d_err, vc_err, m_err};
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (|err_vec_q)  state_d = ST_ERROR;
        else if (!init)  state_d = ST_IDLE;
        else             state_d = ST_INIT;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (|err_vec_q)     state_d = ST_ERROR;
        else if (init)      state_d = ST_INIT;
        else if (all_empty) state_d = ST_IDLE;
        else                state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
    if ((state_q == ST_INIT) && init) begin
      th_main_d = th_main;
      th_vc_d   = th_vc;
      th_d_d    = th_d;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RESET;
      th_main_q <= {{(AW_MAIN+1){1'b1}}, {(AW_MAIN+1){1'b0}}};
      th_vc_q   <= {{(AW_VC+1){1'b1}},   {(AW_VC+1){1'b0}}};
      th_d_q    <= {{(AW_D+1){1'b1}},    {(AW_D+1){1'b0}}};
      err_vec_q <= '0;
      rr_ptr_q  <= '1;
    end else begin
      state_q   <= state_d;
      th_main_q <= th_main_d;
      th_vc_q   <= th_vc_d;
      th_d_q    <= th_d_d;
      err_vec_q <= err_vec_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);
endmodule

// File: tb/tb_trans_layer_param.sv
// Directed bench for trans_layer_param with default parameters (2 VCs, 2 destinations).
module tb_trans_layer_param;
  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        arb_mode;
  logic [5:0]  th_main;
  logic [9:0]  th_vc;
  logic [5:0]  th_d;
  logic [5:0]  data_in;
  logic        push_main;
  logic [1:0]  pop_d;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic [1:0]  dest_empty;
  logic [4:0]  err_vec;
  logic        error_out, active_out, idle_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  trans_layer_param dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .arb_mode   (arb_mode),
    .th_main    (th_main),
    .th_vc      (th_vc),
    .th_d       (th_d),
    .data_in    (data_in),
    .push_main  (push_main),
    .pop_d      (pop_d),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .dest_empty (dest_empty),
    .err_vec    (err_vec),
    .error_out  (error_out),
    .active_out (active_out),
    .idle_out   (idle_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [5:0] w);
    data_in   = w;
    push_main = 1'b1;
    tick();
    push_main = 1'b0;
  endtask

  task automatic wait_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Pop one word from D0 once it is available and compare it.
  task automatic drain0(input logic [5:0] exp, input string tag);
    int unsigned n;
    n = 0;
    while (dest_empty[0] && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(n >= 40), 32'd0);
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    check(tag, {26'd0, data_out[5:0]}, {26'd0, exp});
    check({tag, "_vld"}, {30'd0, valid_out}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; arb_mode = 1'b0;
    th_main = {3'd4, 3'd0}; th_vc = {5'd16, 5'd0}; th_d = {3'd3, 3'd0};
    data_in = '0; push_main = 1'b0; pop_d = '0;
    wait_cycles(3);

    // Reset state
    check("rst_data",   {20'd0, data_out}, 32'd0);
    check("rst_valid",  {30'd0, valid_out}, 32'd0);
    check("rst_dempty", {30'd0, dest_empty}, 32'd3);
    check("rst_err",    {27'd0, err_vec}, 32'd0);
    check("rst_status", {29'd0, error_out, active_out, idle_out}, 32'd0);

    // Bring-up: init high, thresholds latched, then idle
    reset = 1'b1;
    init  = 1'b1;
    wait_cycles(3);
    check("init_status", {29'd0, error_out, active_out, idle_out}, 32'd0);
    init = 1'b0;
    tick();
    check("idle_after_init", {31'd0, idle_out}, 32'd1);
    check("idle_err",        {27'd0, err_vec}, 32'd0);
    check("idle_dempty",     {30'd0, dest_empty}, 32'd3);

    // Single word latency: push at edge 0, dest_empty[0] falls after edge 4
    push_word(6'h05);
    wait_cycles(3);
    check("lat_e3_dempty", {30'd0, dest_empty}, 32'd3);
    tick();
    check("lat_e4_dempty", {30'd0, dest_empty}, 32'd2);
    tick();
    check("lat_active", {29'd0, error_out, active_out, idle_out}, 32'd2);
    pop_d = 2'b01;
    tick();
    pop_d = 2'b00;
    check("pop_data",   {26'd0, data_out[5:0]}, 32'h05);
    check("pop_valid",  {30'd0, valid_out}, 32'd1);
    check("pop_dempty", {30'd0, dest_empty}, 32'd3);
    tick();
    check("pop_valid_drop", {30'd0, valid_out}, 32'd0);
    check("pop_idle", {29'd0, error_out, active_out, idle_out}, 32'd1);

    // Strict priority: stall D0 at its threshold with fillers, load both VCs, drain
    push_word(6'h01); push_word(6'h02); push_word(6'h03);
    wait_cycles(10);
    check("sp_d0_loaded", {30'd0, dest_empty}, 32'd2);
    push_word(6'h20); push_word(6'h20); push_word(6'h00); push_word(6'h00);
    wait_cycles(12);
    check("sp_err", {27'd0, err_vec}, 32'd0);
    drain0(6'h01, "sp_f1");
    drain0(6'h02, "sp_f2");
    drain0(6'h03, "sp_f3");
    drain0(6'h00, "sp_w1");
    drain0(6'h00, "sp_w2");
    drain0(6'h20, "sp_w3");
    drain0(6'h20, "sp_w4");
    wait_cycles(4);
    check("sp_drained", {30'd0, dest_empty}, 32'd3);

    // Round-robin: same loading, mode switched once fillers have landed
    push_word(6'h01); push_word(6'h02); push_word(6'h03);
    wait_cycles(10);
    arb_mode = 1'b1;
    push_word(6'h20); push_word(6'h20); push_word(6'h00); push_word(6'h00);
    wait_cycles(12);
    drain0(6'h01, "rr_f1");
    drain0(6'h02, "rr_f2");
    drain0(6'h03, "rr_f3");
    drain0(6'h00, "rr_w1");
    drain0(6'h20, "rr_w2");
    drain0(6'h00, "rr_w3");
    drain0(6'h20, "rr_w4");
    wait_cycles(4);
    check("rr_idle", {29'd0, error_out, active_out, idle_out}, 32'd1);
    check("rr_err",  {27'd0, err_vec}, 32'd0);

    // Pop of empty D1: sticky error, ERROR state survives init
    pop_d = 2'b10;
    tick();
    pop_d = 2'b00;
    check("uf_err",   {27'd0, err_vec}, 32'h10);
    check("uf_valid", {30'd0, valid_out}, 32'd0);
    tick();
    check("uf_error_out", {29'd0, error_out, active_out, idle_out}, 32'd4);
    init = 1'b1;
    wait_cycles(2);
    check("uf_init_hold", {29'd0, error_out, active_out, idle_out}, 32'd4);
    check("uf_sticky", {27'd0, err_vec}, 32'h10);

    // Reset clears; overflow main FIFO while held in INIT
    reset = 1'b0;
    tick();
    check("rst2_err",    {27'd0, err_vec}, 32'd0);
    check("rst2_status", {29'd0, error_out, active_out, idle_out}, 32'd0);
    reset = 1'b1;
    wait_cycles(2);
    push_word(6'h01); push_word(6'h02); push_word(6'h03); push_word(6'h04);
    check("ovf_pre_err", {27'd0, err_vec}, 32'd0);
    push_word(6'h05);
    check("ovf_err", {27'd0, err_vec}, 32'd1);
    tick();
    check("ovf_error_out", {29'd0, error_out, active_out, idle_out}, 32'd4);
    check("ovf_frozen", {30'd0, dest_empty}, 32'd3);
    init = 1'b0;
    tick();
    check("ovf_hold", {29'd0, error_out, active_out, idle_out}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
